// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and helpers for the 7-segment display scan logic.
package display_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_t;

  typedef logic [1:0] slot_t;

  // Anode pattern with every digit dark for the given drive polarity.
  function automatic logic [3:0] anode_off(input bit active_low);
    return active_low ? 4'b1111 : 4'b0000;
  endfunction

  // Anode pattern lighting exactly one slot for the given drive polarity.
  function automatic logic [3:0] anode_on(input slot_t slot, input bit active_low);
    logic [3:0] onehot;
    onehot = 4'b0001 << slot;
    return active_low ? ~onehot : onehot;
  endfunction

  // Width of a counter running 0..max(div, blank, 2)-1.
  function automatic int unsigned cnt_width(input int unsigned div, input int unsigned blank);
    int unsigned m;
    m = (div > blank) ? div : blank;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/display_scan_scheduler_lz_blank_mask.sv
// Leading-zero blank mask: bit n set when slot n and every slot above it
// hold a zero digit. Slot 0 is never blanked so a value of 0 still shows.
module lz_blank_mask #(
  parameter int unsigned NDIG = 4
) (
  input  logic [4*NDIG-1:0] digits,
  input  logic              en,
  output logic [NDIG-1:0]   mask
);

  logic upper_zero;

  // Walk from the most significant digit down, accumulating "all zero so far".
  always_comb begin
    mask       = '0;
    upper_zero = 1'b1;
    for (int unsigned i = NDIG - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (digits[4*i +: 4] == 4'd0);
      mask[i]    = en && upper_zero;
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed 4-digit 7-segment scan controller with dead-time,
// leading-zero suppression and a frame-coherent digit snapshot.
module display_scan_scheduler
  import display_scan_scheduler_pkg::*;
#(
  parameter int unsigned DIV              = 50000,
  parameter int unsigned BLANK_CYCLES     = 500,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        lz_blank_en,
  input  logic [3:0]  digit1,
  input  logic [3:0]  digit2,
  input  logic [3:0]  digit3,
  input  logic [3:0]  digit4,
  output logic [15:0] digits_q,
  output logic [1:0]  refreshcounter,
  output logic [3:0]  anode,
  output logic        frame_start
);

  localparam int unsigned CW         = cnt_width(DIV, BLANK_CYCLES);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [3:0]  ANODE_DARK = anode_off(ANODE_ACTIVE_LOW);
  // With no dead-time every slot is entered directly in ON.
  localparam scan_state_t SLOT_ENTRY = (BLANK_CYCLES == 0) ? ON : BLANK;

  scan_state_t   state_q, state_d;
  slot_t         slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          take_snap;
  logic [3:0]    anode_d;
  logic [3:0]    blank_mask;

  lz_blank_mask #(
    .NDIG (4)
  ) u_lz_blank_mask (
    .digits (digits_q),
    .en     (lz_blank_en),
    .mask   (blank_mask)
  );

  // State, slot and cycle-counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: dwell counting, slot advance, snapshot on every slot-0 entry.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q + CW'(1);
    take_snap = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      slot_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = SLOT_ENTRY;
          slot_d    = '0;
          cnt_d     = '0;
          take_snap = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end
        end
        ON: begin
          if (cnt_q == DIV_LAST) begin
            state_d   = SLOT_ENTRY;
            slot_d    = slot_q + 2'd1;
            cnt_d     = '0;
            take_snap = (slot_q == 2'd3);
          end
        end
        default: begin
          state_d = IDLE;
          slot_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Anode pattern for the upcoming cycle; the mask reads the held snapshot,
  // which is already valid for slots 1..3, and slot 0 is never masked.
  always_comb begin
    anode_d = ANODE_DARK;
    if (state_d == ON && !blank_mask[slot_d]) begin
      anode_d = anode_on(slot_d, ANODE_ACTIVE_LOW);
    end
  end

  // Registered outputs: anodes, snapshot and frame pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode       <= ANODE_DARK;
      digits_q    <= '0;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_d;
      frame_start <= take_snap;
      if (take_snap) begin
        digits_q <= {digit4, digit3, digit2, digit1};
      end
    end
  end

  assign refreshcounter = slot_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench: two scheduler instances (DIV=4/BLANK=2 active-low, DIV=1/BLANK=0
// active-high) driven in parallel and compared against a frame-position model.
module tb_display_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        lz_blank_en = 1'b0;
  logic [3:0]  digit1 = '0, digit2 = '0, digit3 = '0, digit4 = '0;

  logic [15:0] dq_a, dq_b;
  logic [1:0]  rc_a, rc_b;
  logic [3:0]  an_a, an_b;
  logic        fs_a, fs_b;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;

  // Model: per configuration, position within the frame since enable.
  int          m_div   [2] = '{4, 1};
  int          m_blank [2] = '{2, 0};
  bit          m_al    [2] = '{1'b1, 1'b0};
  bit          m_run   [2];
  int          m_t     [2];
  logic [15:0] m_snap  [2];
  bit          m_lz    [2];

  always #5 clk = ~clk;

  display_scan_scheduler #(
    .DIV              (4),
    .BLANK_CYCLES     (2),
    .ANODE_ACTIVE_LOW (1'b1)
  ) u_dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .lz_blank_en    (lz_blank_en),
    .digit1         (digit1),
    .digit2         (digit2),
    .digit3         (digit3),
    .digit4         (digit4),
    .digits_q       (dq_a),
    .refreshcounter (rc_a),
    .anode          (an_a),
    .frame_start    (fs_a)
  );

  display_scan_scheduler #(
    .DIV              (1),
    .BLANK_CYCLES     (0),
    .ANODE_ACTIVE_LOW (1'b0)
  ) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .lz_blank_en    (lz_blank_en),
    .digit1         (digit1),
    .digit2         (digit2),
    .digit3         (digit3),
    .digit4         (digit4),
    .digits_q       (dq_b),
    .refreshcounter (rc_b),
    .anode          (an_b),
    .frame_start    (fs_b)
  );

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        m_run[c]  = 1'b0;
        m_t[c]    = 0;
        m_snap[c] = '0;
      end else if (!enable) begin
        m_run[c] = 1'b0;
        m_t[c]   = 0;
      end else begin
        if (!m_run[c]) begin
          m_run[c] = 1'b1;
          m_t[c]   = 0;
        end else begin
          m_t[c] = (m_t[c] + 1) % (4 * (m_div[c] + m_blank[c]));
        end
        if (m_t[c] == 0) m_snap[c] = {digit4, digit3, digit2, digit1};
      end
      m_lz[c] = lz_blank_en;
    end
  endtask

  function automatic int exp_slot(input int c);
    return m_run[c] ? m_t[c] / (m_div[c] + m_blank[c]) : 0;
  endfunction

  function automatic logic [3:0] exp_anode(input int c);
    int         per;
    int         slot;
    bit         dark;
    bit         allz;
    logic [3:0] oh;
    logic [15:0] snap;
    oh = 4'b0000;
    if (m_run[c]) begin
      per  = m_div[c] + m_blank[c];
      slot = m_t[c] / per;
      dark = (m_t[c] % per) < m_blank[c];
      snap = m_snap[c];
      if (m_lz[c] && slot > 0) begin
        allz = 1'b1;
        for (int s = slot; s < 4; s++) if (snap[4*s +: 4] != 4'd0) allz = 1'b0;
        if (allz) dark = 1'b1;
      end
      if (!dark) oh = 4'(1 << slot);
    end
    return m_al[c] ? ~oh : oh;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.refreshcounter", 16'(rc_a), 16'(exp_slot(0)));
    chk("a.anode",          16'(an_a), 16'(exp_anode(0)));
    chk("a.frame_start",    16'(fs_a), 16'(m_run[0] && m_t[0] == 0));
    chk("a.digits_q",       dq_a,      m_snap[0]);
    chk("b.refreshcounter", 16'(rc_b), 16'(exp_slot(1)));
    chk("b.anode",          16'(an_b), 16'(exp_anode(1)));
    chk("b.frame_start",    16'(fs_b), 16'(m_run[1] && m_t[1] == 0));
    chk("b.digits_q",       dq_b,      m_snap[1]);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_all();
    end
  endtask

  task automatic set_digits(input logic [3:0] d4, input logic [3:0] d3,
                            input logic [3:0] d2, input logic [3:0] d1);
    digit4 = d4; digit3 = d3; digit2 = d2; digit1 = d1;
  endtask

  // Advance (bounded) until instance A is in the ON part of slot 2.
  task automatic run_to_slot2_on();
    for (int i = 0; i < 60; i++) begin
      if (m_run[0] && m_t[0] == 2 * 6 + 3) break;
      step(1);
    end
    chk("a.reach_slot2", 16'(m_run[0] && m_t[0] == 2 * 6 + 3), 16'd1);
  endtask

  initial begin
    // Reset held with enable high.
    rst_n = 1'b0; enable = 1'b1; lz_blank_en = 1'b1;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    step(3);
    chk("a.reset_anode", 16'(an_a), 16'h000f);
    chk("b.reset_anode", 16'(an_b), 16'h0000);
    chk("a.reset_digits", dq_a, 16'h0000);

    // Plain scan of 1234.
    rst_n = 1'b1;
    step(1);
    chk("a.first_frame_start", 16'(fs_a), 16'd1);
    chk("a.first_snapshot", dq_a, 16'h4321);
    step(2);
    chk("a.first_anode_on", 16'(an_a), 16'b1110);
    step(50);

    // Snapshot coherency: digits change mid slot 2.
    run_to_slot2_on();
    set_digits(4'd8, 4'd7, 4'd6, 4'd5);
    step(1);
    chk("a.snapshot_held", dq_a, 16'h4321);
    step(30);
    chk("a.snapshot_new", dq_a, 16'h8765);

    // Leading zeros: 0047 with and without suppression.
    set_digits(4'd0, 4'd0, 4'd4, 4'd7);
    step(30);
    lz_blank_en = 1'b0;
    step(30);
    lz_blank_en = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    step(30);
    set_digits(4'd0, 4'hA, 4'd0, 4'd0);
    step(30);

    // Enable drop in slot 2 ON, then re-enable.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run_to_slot2_on();
    enable = 1'b0;
    step(1);
    chk("a.drop_rc", 16'(rc_a), 16'd0);
    chk("a.drop_anode", 16'(an_a), 16'h000f);
    step(3);
    enable = 1'b1;
    step(1);
    chk("a.reenable_fs", 16'(fs_a), 16'd1);
    step(40);

    // Randomized traffic: digits biased toward zero, lz toggles, enable drops, resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        digit1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        digit2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        digit3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        digit4 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) lz_blank_en = ~lz_blank_en;
      enable = ($urandom_range(0, 59) != 0);
      rst_n  = ($urandom_range(0, 149) != 0);
      step(1);
    end
    rst_n = 1'b1; enable = 1'b1;
    step(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_scheduler.md
# display_scan_scheduler

Time-multiplexing controller for the 4-digit 7-segment display. Generates the 2-bit `refreshcounter` that selects the active digit in the BCD digit mux, drives the digit anodes with a programmable dead-time between slots, and suppresses leading zeros. Captures a frame-coherent snapshot of the four BCD digits so a display never shows a mix of two counter values. Sits between the binary-to-BCD counter and the BCD digit mux / segment decoder.

## Interface
- `DIV`, 50000: clock cycles a digit anode stays on per slot; must be ≥1.
- `BLANK_CYCLES`, 500: dead-time cycles with all anodes off before each slot; 0 allowed.
- `ANODE_ACTIVE_LOW`, 1: 1 means anode on = 0 (board default).
- `clk`  input  1  system clock; the only clock.
- `rst_n`  input  1  synchronous, active-low reset.
- `enable`  input  1  scan enable; 0 forces display dark.
- `lz_blank_en`  input  1  leading-zero suppression enable.
- `digit1`..`digit4`  input  4 each  live BCD digits (ones, tens, hundreds, thousands).
- `digits_q`  output  16  snapshot {d4,d3,d2,d1}; feeds the digit mux.
- `refreshcounter`  output  2  current slot, 0 = ones (rightmost) .. 3 = thousands.
- `anode`  output  4  one-hot anode drive, bit n = slot n.
- `frame_start`  output  1  one-cycle pulse when slot 0 begins (snapshot taken).

## Operation
- FSM states: IDLE, BLANK, ON.
- IDLE: anodes off, slot = 0. `enable`=1 -> BLANK at slot 0 (or ON if `BLANK_CYCLES`=0).
- BLANK: anodes off; `refreshcounter` already shows the new slot. Lasts `BLANK_CYCLES` cycles, then -> ON.
- ON: anode for current slot asserted unless that slot is blanked. Lasts `DIV` cycles. Then slot increments (3 wraps to 0) and FSM -> BLANK (or ON directly if `BLANK_CYCLES`=0).
- `enable`=0 in any state -> IDLE on the next edge, anodes off, slot 0, cycle counter cleared. This takes precedence over a slot or state change in the same cycle.
- Snapshot: on every entry into slot 0, including from IDLE, `digits_q` ← {digit4, digit3, digit2, digit1}. `frame_start` pulses in that same cycle, registered and coincident with `digits_q` updating. `digits_q` is held otherwise.
- Leading-zero blanking uses the snapshot, when `lz_blank_en`=1:
  - slot 3 is blanked if d4==0;
  - slot 2 is blanked if d4==0 and d3==0;
  - slot 1 is blanked if d4, d3, d2 are all 0;
  - slot 0 is never blanked.
- Digit codes 10–15 count as non-zero.
- `lz_blank_en` is sampled live; a change takes effect on the next cycle.

## Timing
- Reset values:
  - state IDLE, `refreshcounter`=0, `digits_q`=0, `frame_start`=0, cycle counter 0.
  - `anode`=4'b1111 if `ANODE_ACTIVE_LOW`, else 4'b0000.
- All outputs are registered; `anode` changes on the same edge as the state change.
- Frame period is 4×(`DIV`+`BLANK_CYCLES`) cycles; `frame_start` spacing is exactly this while enabled.
- From `enable` rising (sampled at edge k):
  - state and `frame_start` update at edge k+1;
  - first anode on at edge k+1+`BLANK_CYCLES`.
- Cycle counter width is clog2(max(`DIV`,`BLANK_CYCLES`,2)). It counts 0..N−1 and resets on every state or slot change.
- `rst_n` low mid-scan returns everything to reset values on that edge, regardless of `enable`.

## Structure
- Shared display package holds:
  - the state enum (IDLE/BLANK/ON);
  - the slot index type (2-bit);
  - the anode off/on constants derived from `ANODE_ACTIVE_LOW`.
- Sub-module `lz_blank_mask`: combinational, 16-bit snapshot + enable -> 4-bit blank mask. It is reusable for a future 8-digit variant.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `enable`=1 -> `anode`=4'b1111, `refreshcounter`=0, `digits_q`=0, `frame_start`=0.
- Scan sequence with `DIV`=4, `BLANK_CYCLES`=2, digits 1,2,3,4:
  - `refreshcounter` 0,1,2,3,0 with 6-cycle slots;
  - each anode low for exactly 4 cycles after 2 dark cycles;
  - `frame_start` every 24 cycles.
- Leading zeros with snapshot {0,0,4,7}, `lz_blank_en`=1:
  - slots 3 and 2 stay dark, slots 1 and 0 light;
  - with `lz_blank_en`=0, all four light.
- Snapshot coherency: change digits from 1234 to 5678 mid slot 2 -> `digits_q` stays 0x4321 until the next `frame_start`, then becomes 0x8765.
- Enable drop mid-ON at slot 2 -> next cycle IDLE, anodes off, `refreshcounter`=0. Re-enable -> `frame_start` pulse and slot 0 after 2 blank cycles.
- `BLANK_CYCLES`=0, `DIV`=1 -> anodes rotate one slot per cycle with no dark gap; `frame_start` every 4 cycles.
